mef_adub_limp_param: RTL

- Parametrised fertigation tank controller for the automatic irrigation system.
- Supervises a tank with LEVELS thermometer-coded level sensors and drives three actuators: inlet valve (ve), fertiliser mixer (mist) and line-cleaning flush (limp).
- Adds timed mixing and cleaning phases, an apply phase gated by the spray request, and sticky fault detection for sensor codes that are not a valid thermometer code.
- Sits between the sensor front end and the actuator drivers.

---
 rtl/mef_adub_limp_param.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/mef_adub_limp_param.sv
// rtl/mef_adub_limp_param.sv - fertigation tank controller with timed mix/clean phases and sticky sensor fault
module mef_adub_limp_param #(
  parameter int LEVELS       = 3,
  parameter int MIX_CYCLES   = 16,
  parameter int CLEAN_CYCLES = 8,
  parameter int CNT_W        = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              asp,
  input  logic              adub,
  input  logic [LEVELS-1:0] nv,
  output logic              ve,
  output logic              mist,
  output logic              limp,
  output logic              fault,
  output logic [2:0]        state_o
);

  // Width needed to hold a sensor population count of 0..LEVELS.
  localparam int LVL_W = $clog2(LEVELS + 1);

  // Elaboration-time legality of the configuration.
  if (LEVELS < 1) begin : g_bad_levels
    $error("mef_adub_limp_param: LEVELS must be at least 1");
  end
  if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt_w
    $error("mef_adub_limp_param: CNT_W must be in 1..32");
  end
  if (MIX_CYCLES < 1 || longint'(MIX_CYCLES) > ((longint'(1) << CNT_W) - 1)) begin : g_bad_mix
    $error("mef_adub_limp_param: MIX_CYCLES must be in 1..2^CNT_W-1");
  end
  if (CLEAN_CYCLES < 1 || longint'(CLEAN_CYCLES) > ((longint'(1) << CNT_W) - 1)) begin : g_bad_clean
    $error("mef_adub_limp_param: CLEAN_CYCLES must be in 1..2^CNT_W-1");
  end

  // Terminal counter values; phases end on equality, so the counter never wraps.
  localparam logic [CNT_W-1:0] MIX_LAST   = CNT_W'(MIX_CYCLES - 1);
  localparam logic [CNT_W-1:0] CLEAN_LAST = CNT_W'(CLEAN_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_MIX   = 3'd2,
    S_APPLY = 3'd3,
    S_CLEAN = 3'd4,
    S_FAULT = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [LVL_W-1:0]  lvl;
  logic [LEVELS-1:0] thermo;
  logic              valid;
  logic              empty;
  logic              full;

  // Level = number of wet sensors.
  always_comb begin
    lvl = '0;
    for (int i = 0; i < LEVELS; i++) begin
      lvl = lvl + LVL_W'(nv[i]);
    end
  end

  // Ideal thermometer pattern for that level; anything else means a sensor is lying.
  always_comb begin
    thermo = '0;
    for (int i = 0; i < LEVELS; i++) begin
      thermo[i] = (LVL_W'(i) < lvl);
    end
  end

  assign valid = (nv == thermo);
  assign empty = (lvl == '0);
  assign full  = (lvl == LVL_W'(LEVELS));

  // Next-state selection; an invalid sensor code overrides every other rule.
  always_comb begin
    state_d = state_q;
    if (!valid && state_q != S_FAULT) begin
      state_d = S_FAULT;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (empty)           state_d = S_FILL;
          else if (asp && adub) state_d = S_MIX;
          else                 state_d = S_IDLE;
        end
        S_FILL: begin
          if (full) state_d = S_IDLE;
          else      state_d = S_FILL;
        end
        S_MIX: begin
          // An aborted mix still leaves fertiliser in the line, so it is flushed.
          if (!asp)                  state_d = S_CLEAN;
          else if (cnt_q == MIX_LAST) state_d = S_APPLY;
          else                       state_d = S_MIX;
        end
        S_APPLY: begin
          if (!asp || empty) state_d = S_CLEAN;
          else               state_d = S_APPLY;
        end
        S_CLEAN: begin
          if (cnt_q == CLEAN_LAST) state_d = empty ? S_FILL : S_IDLE;
          else                     state_d = S_CLEAN;
        end
        S_FAULT: state_d = S_FAULT;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Phase counter restarts on every state change and runs only in the timed phases.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (state_q == S_MIX || state_q == S_CLEAN) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // State, counter and actuator registers; outputs follow the registered state only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ve      <= 1'b0;
      mist    <= 1'b0;
      limp    <= 1'b0;
      fault   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ve      <= (state_d == S_FILL);
      mist    <= (state_d == S_MIX);
      limp    <= (state_d == S_CLEAN);
      fault   <= (state_d == S_FAULT);
    end
  end

  assign state_o = state_q;

endmodule
